// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order word reads to instruction memory,
// buffers returned words in a small FIFO and hands {pc, instruction} to decode.
//
// state | meaning
// BOOT  | one idle cycle after reset, redirects ignored
// RUN   | issuing requests while outstanding + buffered < DEPTH
// FLUSH | waiting for responses to stale requests to drain, no issue
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [29:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q;
    logic [CW-1:0] outstanding_q, outstanding_next;
    logic [CW-1:0] drop_q, drop_next;
    logic [CW-1:0] count_q;
    logic [PW-1:0] fifo_rd_q, fifo_wr_q;
    logic [PW-1:0] ifq_rd_q, ifq_wr_q;
    logic [CW:0]   occupancy_total;

    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic [31:0] ifq_pc    [DEPTH];

    logic redirect_take, req_fire, rsp_fire, rsp_keep, pop_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign redirect_take    = redirect_valid && (state_q != BOOT);
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign rsp_fire         = imem_rsp_valid && (outstanding_q != '0);
    // A response arriving with a redirect belongs to the old stream and is dropped.
    assign rsp_keep         = rsp_fire && (drop_q == '0) && !redirect_take;
    assign pop_fire         = inst_valid && inst_ready;
    assign occupancy_total  = {1'b0, outstanding_q} + {1'b0, count_q};
    assign outstanding_next = outstanding_q + CW'(req_fire) - CW'(rsp_fire);

    always_comb begin
        drop_next = drop_q;
        if (redirect_take) begin
            drop_next = outstanding_next;
        end else if (rsp_fire && (drop_q != '0)) begin
            drop_next = drop_q - CW'(1);
        end
    end

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                imem_req_valid = !redirect_valid && (occupancy_total < CAP);
                if (redirect_valid) begin
                    state_d = (outstanding_next != '0) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    state_d = (outstanding_next != '0) ? FLUSH : RUN;
                end else if (drop_next == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            ifq_rd_q      <= '0;
            ifq_wr_q      <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_next;
            drop_q        <= drop_next;
            if (redirect_take) begin
                fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
            end else if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (req_fire) ifq_wr_q <= ptr_inc(ifq_wr_q);
            if (rsp_fire) ifq_rd_q <= ptr_inc(ifq_rd_q);
            if (redirect_take) begin
                count_q   <= '0;
                fifo_rd_q <= '0;
                fifo_wr_q <= '0;
            end else begin
                count_q <= count_q + CW'(rsp_keep) - CW'(pop_fire);
                if (rsp_keep) fifo_wr_q <= ptr_inc(fifo_wr_q);
                if (pop_fire) fifo_rd_q <= ptr_inc(fifo_rd_q);
            end
        end
    end

    // Storage needs no reset: occupancy and pointers qualify every read.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            ifq_pc[ifq_wr_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            fifo_pc[fifo_wr_q]   <= ifq_pc[ifq_rd_q];
            fifo_data[fifo_wr_q] <= imem_rsp_data;
        end
    end

    assign imem_req_addr = fetch_pc_q[31:2];
    assign inst_valid    = (count_q != '0);
    assign inst_pc       = inst_valid ? fifo_pc[fifo_rd_q] : '0;
    assign inst_data     = inst_valid ? fifo_data[fifo_rd_q] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-programmable memory model, transaction
// scoreboard checked every cycle, a cycle table for the fill sequence, and corner sequences.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [29:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .inst_ready     (inst_ready)
    );

    typedef struct {
        logic [29:0] addr;
        logic        stale;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    typedef struct {
        logic        rr;
        logic        ir;
        logic        rv;
        logic [29:0] addr;
        logic        iv;
        logic [31:0] ipc;
        logic        chk_pc;
    } vec_t;

    req_t        pend_q[$];
    inst_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_count = 0;
    logic        boot = 1'b1;
    logic [29:0] exp_addr = RESET_PC[31:2];
    logic        obs_stale, obs_rv, obs_redir;
    req_t        obs_r;
    vec_t        vec[9];

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a[15:0] ^ 16'hC3A5, 2'b10, a[29:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory: in-order responses exactly lat cycles after accept.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Scoreboard: requests tagged at accept, stale-marked on redirect, expected
    // instructions queued on live responses and compared when decode pops.
    always @(negedge clk) begin
        if (reset) begin
            pend_q.delete();
            exp_q.delete();
            boot      = 1'b1;
            exp_addr  = RESET_PC[31:2];
            acc_count = 0;
        end else begin
            obs_stale = 1'b0;
            for (int i = 0; i < pend_q.size(); i++) begin
                if (pend_q[i].stale) obs_stale = 1'b1;
            end
            obs_redir = redirect_valid && !boot;
            obs_rv = !boot && !redirect_valid && !obs_stale &&
                     (pend_q.size() + exp_q.size() < DEPTH);
            check("sb_req_valid", 32'(imem_req_valid), 32'(obs_rv));
            check("sb_inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
            if (inst_valid && inst_ready && exp_q.size() != 0) begin
                check("sb_inst_pc", inst_pc, exp_q[0].pc);
                check("sb_inst_data", inst_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                check("sb_req_addr", 32'(imem_req_addr), 32'(exp_addr));
                pend_q.push_back('{addr: exp_addr, stale: 1'b0, due: cyc + lat});
                exp_addr = exp_addr + 30'd1;
                acc_count++;
            end
            if (imem_rsp_valid && pend_q.size() != 0) begin
                obs_r = pend_q.pop_front();
                if (!obs_r.stale && !obs_redir) begin
                    exp_q.push_back('{pc: {obs_r.addr, 2'b00}, data: mem_word(obs_r.addr)});
                end
            end
            if (obs_redir) begin
                for (int i = 0; i < pend_q.size(); i++) begin
                    req_t t;
                    t = pend_q[i];
                    t.stale = 1'b1;
                    pend_q[i] = t;
                end
                exp_q.delete();
                exp_addr = redirect_pc[31:2];
            end
            boot = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Returns at a negedge with the condition true, or ok=0 after the budget.
    task automatic wait_rv(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_iv(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        logic found;

        // Fill sequence, ready=1, 1-cycle memory: issue cap of 2 gives 2 insts per 3 cycles.
        vec[0] = '{1'b1, 1'b1, 1'b0, 30'd0, 1'b0, 32'h0, 1'b1};
        vec[1] = '{1'b1, 1'b1, 1'b1, 30'd0, 1'b0, 32'h0, 1'b0};
        vec[2] = '{1'b1, 1'b1, 1'b1, 30'd1, 1'b0, 32'h0, 1'b0};
        vec[3] = '{1'b1, 1'b1, 1'b0, 30'd0, 1'b1, 32'h0, 1'b1};
        vec[4] = '{1'b1, 1'b1, 1'b1, 30'd2, 1'b1, 32'h4, 1'b1};
        vec[5] = '{1'b1, 1'b1, 1'b1, 30'd3, 1'b0, 32'h0, 1'b0};
        vec[6] = '{1'b1, 1'b1, 1'b0, 30'd0, 1'b1, 32'h8, 1'b1};
        vec[7] = '{1'b1, 1'b1, 1'b1, 30'd4, 1'b1, 32'hC, 1'b1};
        vec[8] = '{1'b1, 1'b1, 1'b1, 30'd5, 1'b0, 32'h0, 1'b0};

        // Streaming fill from reset
        lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            imem_req_ready = vec[i].rr;
            inst_ready     = vec[i].ir;
            @(negedge clk);
            check("t1_req_valid", 32'(imem_req_valid), 32'(vec[i].rv));
            if (vec[i].rv) check("t1_req_addr", 32'(imem_req_addr), 32'(vec[i].addr));
            check("t1_inst_valid", 32'(inst_valid), 32'(vec[i].iv));
            if (vec[i].chk_pc) check("t1_inst_pc", inst_pc, vec[i].ipc);
            if (vec[i].iv) check("t1_inst_data", inst_data, mem_word(vec[i].ipc[31:2]));
            step();
        end

        // Decode stalled: issue caps at DEPTH, then drains in order
        lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        do_reset();
        repeat (8) begin
            @(negedge clk);
            step();
        end
        @(negedge clk);
        check("t2_accepts", 32'(acc_count), 32'd2);
        check("t2_req_valid_capped", 32'(imem_req_valid), 32'd0);
        check("t2_full_valid", 32'(inst_valid), 32'd1);
        check("t2_head_pc", inst_pc, 32'h0);
        step();
        inst_ready = 1'b1;
        @(negedge clk);
        check("t2_drain0_pc", inst_pc, 32'h0);
        check("t2_drain0_req", 32'(imem_req_valid), 32'd0);
        step();
        @(negedge clk);
        check("t2_drain1_pc", inst_pc, 32'h4);
        check("t2_resume_valid", 32'(imem_req_valid), 32'd1);
        check("t2_resume_addr", 32'(imem_req_addr), 32'd2);
        step();

        // Memory back-pressure: request held stable
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        do_reset();
        @(negedge clk);
        step();
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(imem_req_valid), 32'd1);
            check("t3_hold_addr", 32'(imem_req_addr), 32'd0);
            step();
        end
        imem_req_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            step();
        end

        // Redirect with two in flight: flush, then restart at 0x100
        lat = 4;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        repeat (3) begin
            @(negedge clk);
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check("t4_redirect_req", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_flush_req", 32'(imem_req_valid), 32'd0);
        step();
        wait_rv(ok);
        check("t4_resume_seen", 32'(ok), 32'd1);
        check("t4_resume_addr", 32'(imem_req_addr), 32'h40);
        step();
        wait_iv(ok);
        check("t4_first_seen", 32'(ok), 32'd1);
        check("t4_first_pc", inst_pc, 32'h100);
        check("t4_first_data", inst_data, mem_word(30'h40));
        step();

        // Redirect coincident with a response, another request still in flight
        lat = 2;
        do_reset();
        repeat (3) begin
            @(negedge clk);
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        @(negedge clk);
        step();
        redirect_valid = 1'b0;
        wait_rv(ok);
        check("t5_resume_seen", 32'(ok), 32'd1);
        check("t5_resume_addr", 32'(imem_req_addr), 32'h80);
        step();
        wait_iv(ok);
        check("t5_first_seen", 32'(ok), 32'd1);
        check("t5_first_pc", inst_pc, 32'h200);
        step();

        // Reset mid-stream with the FIFO full
        lat = 1;
        inst_ready = 1'b0;
        do_reset();
        repeat (6) begin
            @(negedge clk);
            step();
        end
        @(negedge clk);
        check("t6_full_before", 32'(inst_valid), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_inst_valid", 32'(inst_valid), 32'd0);
        check("t6_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        @(negedge clk);
        check("t6_restart_valid", 32'(imem_req_valid), 32'd1);
        check("t6_restart_addr", 32'(imem_req_addr), 32'(RESET_PC[31:2]));
        step();

        // Redirect during BOOT ignored; PC wraps past 0xFFFF_FFFC
        inst_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0500;
        @(negedge clk);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t7_boot_redirect_addr", 32'(imem_req_addr), 32'(RESET_PC[31:2]));
        step();
        repeat (4) begin
            @(negedge clk);
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && inst_pc == 32'h0) found = 1'b1;
            step();
        end
        check("t7_wrap_to_zero", 32'(found), 32'd1);
        repeat (4) begin
            @(negedge clk);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
